// File: rtl/trace_formatter.sv
// trace_formatter: turns retired-write events into ASCII trace lines,
// one character per clock:
//   ^<time>@<pc>: $<reg> <= <data>#    (register write)
//   ^<time>@<pc>: *<addr> <= <data>#   (memory write)
// Optional build macro TRACE_TIME_PAD_EN: TIME is always printed as four
// zero-padded decimal digits instead of the minimal-digit form.
module trace_formatter (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_kind,
    input  logic [13:0] in_time,
    input  logic [31:0] in_pc,
    input  logic [4:0]  in_reg,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_data,
    output logic [7:0]  char,
    output logic        char_valid,
    output logic        line_done
);

    typedef enum logic [3:0] {
        S_IDLE, S_CARET, S_TIME, S_AT, S_PC, S_COLON, S_SP1, S_KIND,
        S_DEST, S_SP2, S_LT, S_EQ, S_SP3, S_DATA, S_HASH
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        kind_q, kind_d;
    logic [15:0] bcd_q, bcd_d;      // saturated time as 4 BCD digits
    logic [31:0] pc_q, pc_d;
    logic [31:0] dest_q, dest_d;    // reg number (zero-extended) or address
    logic [31:0] data_q, data_d;
    logic [7:0]  char_q, char_d;
    logic        valid_q, valid_d;
    logic        done_q, done_d;

    logic        accept;
    logic [13:0] time_sat;
    logic [2:0]  time_len;
    logic [1:0]  reg_len;
    logic [3:0]  dest_last;
    logic [2:0]  time_pos;
    logic [3:0]  time_digit;
    logic [3:0]  reg_tens;
    logic [3:0]  reg_ones;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    function automatic logic [7:0] dec_char(input logic [3:0] d);
        return 8'h30 + {4'h0, d};
    endfunction

    // Nibble idx counted from the most significant end (0 = bits 31:28).
    function automatic logic [3:0] nibble(input logic [31:0] w, input logic [2:0] idx);
        logic [3:0] n;
        case (idx)
            3'd0:    n = w[31:28];
            3'd1:    n = w[27:24];
            3'd2:    n = w[23:20];
            3'd3:    n = w[19:16];
            3'd4:    n = w[15:12];
            3'd5:    n = w[11:8];
            3'd6:    n = w[7:4];
            default: n = w[3:0];
        endcase
        return n;
    endfunction

    assign in_ready = (state_q == S_IDLE) || (state_q == S_HASH);
    assign accept   = in_valid & in_ready;
    assign time_sat = (in_time > 14'd9999) ? 14'd9999 : in_time;

    // Field widths derived from the held event.
    always_comb begin
`ifdef TRACE_TIME_PAD_EN
        time_len = 3'd4;
`else
        if (bcd_q[15:12] != 4'd0)      time_len = 3'd4;
        else if (bcd_q[11:8] != 4'd0)  time_len = 3'd3;
        else if (bcd_q[7:4] != 4'd0)   time_len = 3'd2;
        else                           time_len = 3'd1;
`endif
        reg_len   = (dest_q[4:0] >= 5'd10) ? 2'd2 : 2'd1;
        dest_last = kind_q ? {2'b00, reg_len} - 4'd1 : 4'd7;
        reg_tens  = 4'(dest_q[4:0] / 5'd10);
        reg_ones  = 4'(dest_q[4:0] % 5'd10);
    end

    // Next state, digit counter and event capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        kind_d  = kind_q;
        bcd_d   = bcd_q;
        pc_d    = pc_q;
        dest_d  = dest_q;
        data_d  = data_q;
        if (accept) begin
            kind_d = in_kind;
            bcd_d  = {4'(time_sat / 14'd1000), 4'((time_sat / 14'd100) % 14'd10),
                      4'((time_sat / 14'd10) % 14'd10), 4'(time_sat % 14'd10)};
            pc_d   = in_pc;
            dest_d = in_kind ? {27'd0, in_reg} : in_addr;
            data_d = in_data;
        end
        case (state_q)
            S_IDLE:  if (accept) state_d = S_CARET;
            S_CARET: begin state_d = S_TIME; cnt_d = '0; end
            S_TIME:  begin
                if (cnt_q == {1'b0, time_len} - 4'd1) state_d = S_AT;
                else cnt_d = cnt_q + 4'd1;
            end
            S_AT:    begin state_d = S_PC; cnt_d = '0; end
            S_PC:    begin
                if (cnt_q == 4'd7) state_d = S_COLON;
                else cnt_d = cnt_q + 4'd1;
            end
            S_COLON: state_d = S_SP1;
            S_SP1:   state_d = S_KIND;
            S_KIND:  begin state_d = S_DEST; cnt_d = '0; end
            S_DEST:  begin
                if (cnt_q == dest_last) state_d = S_SP2;
                else cnt_d = cnt_q + 4'd1;
            end
            S_SP2:   state_d = S_LT;
            S_LT:    state_d = S_EQ;
            S_EQ:    state_d = S_SP3;
            S_SP3:   begin state_d = S_DATA; cnt_d = '0; end
            S_DATA:  begin
                if (cnt_q == 4'd7) state_d = S_HASH;
                else cnt_d = cnt_q + 4'd1;
            end
            S_HASH:  state_d = accept ? S_CARET : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output character for the state being entered, so outputs are registered.
    always_comb begin
        time_pos = time_len - 3'd1 - cnt_d[2:0];
        case (time_pos)
            3'd3:    time_digit = bcd_q[15:12];
            3'd2:    time_digit = bcd_q[11:8];
            3'd1:    time_digit = bcd_q[7:4];
            default: time_digit = bcd_q[3:0];
        endcase
        char_d  = 8'h00;
        valid_d = (state_d != S_IDLE);
        done_d  = (state_d == S_HASH);
        case (state_d)
            S_CARET: char_d = 8'h5e;
            S_TIME:  char_d = dec_char(time_digit);
            S_AT:    char_d = 8'h40;
            S_PC:    char_d = hex_char(nibble(pc_q, cnt_d[2:0]));
            S_COLON: char_d = 8'h3a;
            S_SP1, S_SP2, S_SP3: char_d = 8'h20;
            S_KIND:  char_d = kind_q ? 8'h24 : 8'h2a;
            S_DEST:  begin
                if (kind_q)
                    char_d = dec_char((reg_len == 2'd2 && cnt_d == 4'd0) ? reg_tens : reg_ones);
                else
                    char_d = hex_char(nibble(dest_q, cnt_d[2:0]));
            end
            S_LT:    char_d = 8'h3c;
            S_EQ:    char_d = 8'h3d;
            S_DATA:  char_d = hex_char(nibble(data_q, cnt_d[2:0]));
            S_HASH:  char_d = 8'h23;
            default: char_d = 8'h00;
        endcase
    end

    // State, holding and output registers; reset abandons any line at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            kind_q  <= 1'b0;
            bcd_q   <= '0;
            pc_q    <= '0;
            dest_q  <= '0;
            data_q  <= '0;
            char_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            kind_q  <= kind_d;
            bcd_q   <= bcd_d;
            pc_q    <= pc_d;
            dest_q  <= dest_d;
            data_q  <= data_d;
            char_q  <= char_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign char       = char_q;
    assign char_valid = valid_q;
    assign line_done  = done_q;

endmodule
